sap_cpu_param: RTL and testbench

- Parametrised successor to the team's 8-bit accumulator CPU: a microcoded accumulator machine with width and depth set by parameters.
- Adds carry flag, BNE/BCS branches, HLT, a variable-length microsequence (no fixed 8-step frame) and a valid/ready output handshake.
- Sits in the Tiny Tapeout user design between the programming interface and the UART transmitter.

---
 rtl/sap_cpu_param.sv | 230 +++++++++++++++++++++++
 tb/tb_sap_cpu_param.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sap_cpu_param.sv
// sap_cpu_param: parametrised microcoded accumulator CPU with carry/zero flags and a valid/ready output port.
// Optional build macro SAP_CPU_SHIFT_EN enables SHL/SHR (opcodes C/D); without it they execute as NOP.
module sap_cpu_param #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              prog,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              halted
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned OP_W  = 4;

    typedef enum logic [OP_W-1:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_ADD = 4'h2,
        OP_OUT = 4'h3,
        OP_JMP = 4'h4,
        OP_STA = 4'h5,
        OP_LDI = 4'h6,
        OP_SUB = 4'h7,
        OP_BEQ = 4'h8,
        OP_CMP = 4'h9,
        OP_BNE = 4'hA,
        OP_BCS = 4'hB,
        OP_SHL = 4'hC,
        OP_SHR = 4'hD,
        OP_RSV = 4'hE,
        OP_HLT = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        S_F1,
        S_F2,
        S_E1,
        S_E2,
        S_E3,
        S_OWAIT,
        S_HALT
    } state_e;

    state_e              state, state_nxt;
    logic [ADDR_W-1:0]   pc, pc_nxt;
    logic [ADDR_W-1:0]   mar, mar_nxt;
    opcode_e             ir_op, ir_op_nxt;
    logic [ADDR_W-1:0]   ir_opd, ir_opd_nxt;
    logic [DATA_W-1:0]   a, a_nxt;
    logic [DATA_W-1:0]   b, b_nxt;
    logic                z, z_nxt;
    logic                c, c_nxt;
    logic [DATA_W-1:0]   out_data_nxt;
    logic                out_valid_nxt;
    logic                halted_nxt;

    logic [DATA_W-1:0]   ram [DEPTH];
    logic [DATA_W-1:0]   ram_rdata;
    logic                ram_we;
    logic [ADDR_W-1:0]   ram_waddr;
    logic [DATA_W-1:0]   ram_wdata;

    // ALU results carry one extra bit: carry-out for ADD, borrow for SUB/CMP
    logic [DATA_W:0]     sum;
    logic [DATA_W:0]     diff;

    assign ram_rdata = ram[mar];
    assign sum       = {1'b0, a} + {1'b0, b};
    assign diff      = {1'b0, a} - {1'b0, b};

    // Next-state and datapath control
    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        mar_nxt       = mar;
        ir_op_nxt     = ir_op;
        ir_opd_nxt    = ir_opd;
        a_nxt         = a;
        b_nxt         = b;
        z_nxt         = z;
        c_nxt         = c;
        out_data_nxt  = out_data;
        out_valid_nxt = out_valid;
        halted_nxt    = halted;
        ram_we        = 1'b0;
        ram_waddr     = mar;
        ram_wdata     = a;

        if (prog) begin
            // Programming takes RAM and restarts the core at address 0
            ram_we        = 1'b1;
            ram_waddr     = prog_addr;
            ram_wdata     = prog_data;
            pc_nxt        = '0;
            z_nxt         = 1'b0;
            c_nxt         = 1'b0;
            out_valid_nxt = 1'b0;
            halted_nxt    = 1'b0;
            state_nxt     = S_F1;
        end else begin
            unique case (state)
                S_F1: begin
                    mar_nxt   = pc;
                    state_nxt = S_F2;
                end
                S_F2: begin
                    ir_op_nxt  = opcode_e'(ram_rdata[DATA_W-1 -: OP_W]);
                    ir_opd_nxt = ram_rdata[ADDR_W-1:0];
                    pc_nxt     = pc + ADDR_W'(1);
                    state_nxt  = S_E1;
                end
                S_E1: begin
                    state_nxt = S_F1;
                    case (ir_op)
                        OP_LDA, OP_STA, OP_ADD, OP_SUB, OP_CMP: begin
                            mar_nxt   = ir_opd;
                            state_nxt = S_E2;
                        end
                        OP_LDI: a_nxt = DATA_W'(ir_opd);
                        OP_JMP: pc_nxt = ir_opd;
                        OP_BEQ: if (z)  pc_nxt = ir_opd;
                        OP_BNE: if (!z) pc_nxt = ir_opd;
                        OP_BCS: if (c)  pc_nxt = ir_opd;
                        OP_OUT: begin
                            out_data_nxt  = a;
                            out_valid_nxt = 1'b1;
                            state_nxt     = S_OWAIT;
                        end
                        OP_HLT: begin
                            halted_nxt = 1'b1;
                            state_nxt  = S_HALT;
                        end
`ifdef SAP_CPU_SHIFT_EN
                        OP_SHL: begin
                            a_nxt = {a[DATA_W-2:0], 1'b0};
                            c_nxt = a[DATA_W-1];
                            z_nxt = (a[DATA_W-2:0] == '0);
                        end
                        OP_SHR: begin
                            a_nxt = {1'b0, a[DATA_W-1:1]};
                            c_nxt = a[0];
                            z_nxt = (a[DATA_W-1:1] == '0);
                        end
`endif
                        default: state_nxt = S_F1;
                    endcase
                end
                S_E2: begin
                    state_nxt = S_F1;
                    case (ir_op)
                        OP_LDA: a_nxt = ram_rdata;
                        OP_STA: ram_we = 1'b1;
                        OP_ADD, OP_SUB, OP_CMP: begin
                            b_nxt     = ram_rdata;
                            state_nxt = S_E3;
                        end
                        default: state_nxt = S_F1;
                    endcase
                end
                S_E3: begin
                    state_nxt = S_F1;
                    case (ir_op)
                        OP_ADD: begin
                            a_nxt = sum[DATA_W-1:0];
                            c_nxt = sum[DATA_W];
                            z_nxt = (sum[DATA_W-1:0] == '0);
                        end
                        OP_SUB, OP_CMP: begin
                            if (ir_op == OP_SUB) a_nxt = diff[DATA_W-1:0];
                            c_nxt = ~diff[DATA_W];
                            z_nxt = (diff[DATA_W-1:0] == '0);
                        end
                        default: state_nxt = S_F1;
                    endcase
                end
                S_OWAIT: begin
                    if (out_ready) begin
                        out_valid_nxt = 1'b0;
                        state_nxt     = S_F1;
                    end
                end
                S_HALT:  state_nxt = S_HALT;
                default: state_nxt = S_F1;
            endcase
        end
    end

    // State and architectural registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_F1;
            pc        <= '0;
            mar       <= '0;
            ir_op     <= OP_NOP;
            ir_opd    <= '0;
            a         <= '0;
            b         <= '0;
            z         <= 1'b0;
            c         <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            halted    <= 1'b0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            mar       <= mar_nxt;
            ir_op     <= ir_op_nxt;
            ir_opd    <= ir_opd_nxt;
            a         <= a_nxt;
            b         <= b_nxt;
            z         <= z_nxt;
            c         <= c_nxt;
            out_data  <= out_data_nxt;
            out_valid <= out_valid_nxt;
            halted    <= halted_nxt;
        end
    end

    // Program/data RAM keeps its contents across reset
    always_ff @(posedge clk) begin
        if (ram_we) ram[ram_waddr] <= ram_wdata;
    end

endmodule

// File: tb/tb_sap_cpu_param.sv
// tb_sap_cpu_param: scoreboard bench; an instruction-level reference model predicts each output
// transfer, halt event and the idle-cycle gap before it, while a monitor checks what the DUT presents.
module tb_sap_cpu_param;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          prog;
    logic [AW-1:0] prog_addr;
    logic [DW-1:0] prog_data;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          halted;

    always #5 clk = ~clk;

    sap_cpu_param #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .prog      (prog),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .halted    (halted)
    );

    typedef struct packed {
        logic          is_halt;
        logic [DW-1:0] data;
        logic [15:0]   gap;
    } ev_t;

    ev_t           expq[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    logic [DW-1:0] prog_img [16];
    logic [DW-1:0] m_ram [16];
    logic [DW-1:0] m_a = '0;
    bit            run_active = 0;
    bit            open_ended = 0;
    bit            force_low = 0;
    int            gap = 0;
    bit            valid_seen = 0;
    bit            halt_seen = 0;
    logic [DW-1:0] held = '0;

    function automatic void check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic logic [DW-1:0] ins(input int op, input int opd);
        return DW'((op << 4) | opd);
    endfunction

    // Reference: run the program one instruction at a time, recording events and cycle gaps
    task automatic model_run(input int max_steps);
        int pc = 0;
        int cyc = 0;
        int op, opd, t, r;
        ev_t ev;
        bit m_z = 0, m_c = 0;
        for (int k = 0; k < 16; k++) m_ram[k] = prog_img[k];
        for (int s = 0; s < max_steps; s++) begin
            op  = int'(m_ram[pc]) / 16;
            opd = int'(m_ram[pc]) % 16;
            pc  = (pc + 1) % 16;
            case (op)
                1: begin m_a = m_ram[opd]; cyc += 4; end
                2: begin
                    t   = int'(m_a) + int'(m_ram[opd]);
                    m_a = DW'(t % 256);
                    m_c = (t >= 256);
                    m_z = (t % 256 == 0);
                    cyc += 5;
                end
                7, 9: begin
                    r   = (int'(m_a) - int'(m_ram[opd]) + 256) % 256;
                    m_c = (m_a >= m_ram[opd]);
                    m_z = (r == 0);
                    if (op == 7) m_a = DW'(r);
                    cyc += 5;
                end
                3: begin
                    ev.is_halt = 0; ev.data = m_a; ev.gap = 16'(cyc + 3);
                    expq.push_back(ev);
                    cyc = 0;
                end
                4: begin pc = opd; cyc += 3; end
                5: begin m_ram[opd] = m_a; cyc += 4; end
                6: begin m_a = DW'(opd); cyc += 3; end
                8:  begin if (m_z)  pc = opd; cyc += 3; end
                10: begin if (!m_z) pc = opd; cyc += 3; end
                11: begin if (m_c)  pc = opd; cyc += 3; end
`ifdef SAP_CPU_SHIFT_EN
                12: begin
                    m_c = (m_a >= 128);
                    m_a = DW'((int'(m_a) * 2) % 256);
                    m_z = (m_a == 0);
                    cyc += 3;
                end
                13: begin
                    m_c = m_a[0];
                    m_a = DW'(int'(m_a) / 2);
                    m_z = (m_a == 0);
                    cyc += 3;
                end
`endif
                15: begin
                    ev.is_halt = 1; ev.data = '0; ev.gap = 16'(cyc + 3);
                    expq.push_back(ev);
                    return;
                end
                default: cyc += 3;
            endcase
        end
    endtask

    // Output consumer: random back-pressure unless a stall is being forced
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            out_ready = force_low ? 1'b0 : ($urandom_range(0, 2) != 0);
        end
    end

    // Monitor: pop and compare on each new transfer or halt; count idle cycles between them
    initial begin : monitor
        ev_t e;
        forever begin
            @(negedge clk);
            if (run_active) begin
                if (out_valid) begin
                    if (!valid_seen) begin
                        valid_seen = 1;
                        held = out_data;
                        if (expq.size() == 0) begin
                            if (!open_ended) check("unexpected_out", out_valid, 0);
                        end else begin
                            e = expq.pop_front();
                            check("event_kind", halted, e.is_halt);
                            check("out_data", out_data, e.data);
                            check("out_gap", gap, e.gap);
                        end
                    end else begin
                        check("out_stable", out_data, held);
                    end
                    if (out_ready) begin
                        valid_seen = 0;
                        gap = 0;
                    end
                end else if (halted) begin
                    if (!halt_seen) begin
                        halt_seen = 1;
                        if (expq.size() == 0) begin
                            if (!open_ended) check("unexpected_halt", halted, 0);
                        end else begin
                            e = expq.pop_front();
                            check("event_kind", halted, e.is_halt);
                            check("halt_gap", gap, e.gap);
                        end
                    end
                end else begin
                    gap++;
                end
            end
        end
    end

    task automatic clear_img();
        for (int i = 0; i < 16; i++) prog_img[i] = '0;
    endtask

    task automatic arm_monitor(input bit oe);
        open_ended = oe;
        gap = 0;
        valid_seen = 0;
        halt_seen = 0;
        run_active = 1;
    endtask

    task automatic run_prog(input int max_steps, input bit oe);
        expq.delete();
        model_run(max_steps);
        prog = 1'b1;
        for (int i = 0; i < 16; i++) begin
            prog_addr = AW'(i);
            prog_data = prog_img[i];
            @(posedge clk);
            #1;
        end
        prog = 1'b0;
        arm_monitor(oe);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (n < budget) begin
            @(negedge clk);
            n++;
            if (expq.size() == 0 && (open_ended || halt_seen)) break;
        end
        check("halted_at_end", halted, open_ended ? 0 : 1);
        check("pending_events", expq.size(), 0);
        run_active = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int budget);
        for (int i = 0; i < budget && !out_valid; i++) @(negedge clk);
        check("valid_rise", out_valid, 1);
    endtask

    // Asynchronous reset mid-cycle; outputs must clear before any clock edge
    task automatic reset_pulse(input bit keep_prog);
        run_active = 0;
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_halted", halted, 0);
        m_a = '0;
        prog = keep_prog;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int op, opd;
        reset_n   = 1'b0;
        prog      = 1'b1;
        prog_addr = '0;
        prog_data = '0;
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 0);
        check("reset_halted", halted, 0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // LDI 5; ADD 15; OUT; HLT with ram[15]=3
        clear_img();
        prog_img[0] = ins(6, 5); prog_img[1] = ins(2, 15);
        prog_img[2] = ins(3, 0); prog_img[3] = ins(15, 0);
        prog_img[15] = 8'h03;
        run_prog(100, 0);
        wait_done(500);

        // ADD overflow to zero sets Z and C; BCS and BEQ taken
        clear_img();
        prog_img[0] = ins(6, 1);  prog_img[1] = ins(2, 15); prog_img[2] = ins(11, 7);
        prog_img[3] = ins(3, 0);  prog_img[4] = ins(15, 0);
        prog_img[7] = ins(3, 0);  prog_img[8] = ins(8, 10); prog_img[9] = ins(15, 0);
        prog_img[10] = ins(6, 6); prog_img[11] = ins(3, 0); prog_img[12] = ins(15, 0);
        prog_img[15] = 8'hFF;
        run_prog(100, 0);
        wait_done(500);

        // CMP equal: a kept, BNE not taken, BEQ and BCS taken
        clear_img();
        prog_img[0] = ins(6, 3);  prog_img[1] = ins(9, 14); prog_img[2] = ins(10, 6);
        prog_img[3] = ins(8, 5);  prog_img[4] = ins(15, 0); prog_img[5] = ins(3, 0);
        prog_img[6] = ins(11, 8); prog_img[7] = ins(15, 0); prog_img[8] = ins(3, 0);
        prog_img[9] = ins(15, 0); prog_img[14] = 8'h03;
        run_prog(100, 0);
        wait_done(500);

        // Consumer stalls for 10 cycles while the value is presented
        clear_img();
        prog_img[0] = ins(6, 5); prog_img[1] = ins(2, 15);
        prog_img[2] = ins(3, 0); prog_img[3] = ins(15, 0);
        prog_img[15] = 8'h03;
        force_low = 1;
        run_prog(100, 0);
        wait_valid(100);
        repeat (10) @(negedge clk);
        check("stall_valid_held", out_valid, 1);
        check("stall_not_halted", halted, 0);
        @(posedge clk);
        #1;
        force_low = 0;
        wait_done(500);

        // Reset while an output is pending; RAM survives and execution restarts at 0
        force_low = 1;
        run_prog(100, 0);
        wait_valid(100);
        repeat (3) @(negedge clk);
        reset_pulse(0);
        force_low = 0;
        expq.delete();
        model_run(100);
        arm_monitor(0);
        wait_done(500);

        // Counter loop that falls through NOPs to address 15 and wraps to 0
        clear_img();
        prog_img[0] = ins(1, 14); prog_img[1] = ins(2, 13);
        prog_img[2] = ins(5, 14); prog_img[3] = ins(3, 0);
        prog_img[13] = 8'h01;
        run_prog(60, 1);
        wait_done(1500);
        reset_pulse(1);

        // Shifts (NOP when the shift option is not built)
        clear_img();
        prog_img[0] = ins(1, 15); prog_img[1] = ins(12, 0); prog_img[2] = ins(11, 4);
        prog_img[3] = ins(15, 0); prog_img[4] = ins(3, 0);  prog_img[5] = ins(13, 0);
        prog_img[6] = ins(3, 0);  prog_img[7] = ins(15, 0);
        prog_img[15] = 8'h81;
        run_prog(100, 0);
        wait_done(500);

        // Random forward-only programs: code 0..9, HLT at 10, data 11..15
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < 10; i++) begin
                op = int'($urandom_range(0, 15));
                case (op)
                    1, 2, 5, 7, 9:  opd = int'($urandom_range(11, 15));
                    4, 8, 10, 11:   opd = int'($urandom_range(i + 1, 10));
                    default:        opd = int'($urandom_range(0, 15));
                endcase
                prog_img[i] = ins(op, opd);
            end
            prog_img[10] = ins(15, 0);
            for (int i = 11; i < 16; i++) prog_img[i] = DW'($urandom);
            run_prog(100, 0);
            wait_done(1000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
